regfile_dump_tx: RTL and testbench
==================================

// Module: regfile_dump_tx
// PURPOSE
//  Debug reader for the register file's external read port (addr_e/data_e).
//  On a start pulse, walks registers FIRST_REG..LAST_REG and streams them out as
//  a byte frame over a valid/ready interface (to a UART TX or a debug FIFO).
//  Frame: HEADER, then per register {index, data[7:0], [15:8], [23:16], [31:24]},
//  then one XOR checksum byte.
// PARAMETERS
//  FIRST_REG  1      first register index dumped (0..31)
//  LAST_REG   31     last register index dumped (FIRST_REG..31)
//  HEADER     8'hA5  frame start byte; not included in the checksum
// PORTS
//  clk       in   1   single clock; all state on posedge clk
//  rst       in   1   synchronous reset, active-high
//  start     in   1   1-cycle request to begin a dump; ignored while busy
//  addr_e    out  5   register index driven to the regfile external read port
//  data_e    in   32  combinational regfile read data for addr_e
//  tx_data   out  8   byte to transmit
//  tx_valid  out  1   tx_data is valid
//  tx_ready  in   1   sink accepts the byte when tx_valid && tx_ready
//  busy      out  1   high from the cycle after start until the done pulse
//  done      out  1   1-cycle pulse after the checksum byte handshake
// BEHAVIOUR
//  Reset: tx_valid=0, tx_data=0, addr_e=0, busy=0, done=0, csum=0, state IDLE.
//   Reset mid-frame aborts the frame. There is no partial resume.
//  FSM: IDLE -> HDR -> LOAD -> IDX -> DATA(x4) -> {LOAD | CSUM} -> DONE -> IDLE.
//  IDLE: start=1 -> reg_idx<=FIRST_REG, addr_e<=FIRST_REG, csum<=0, busy<=1.
//   Next cycle: tx_valid=1, tx_data=HEADER (state HDR).
//  LOAD (one cycle, tx_valid=0): shift<=data_e for current addr_e.
//   Next state is IDX.
//  IDX: tx_data=reg_idx (zero-extended to 8 bits). DATA: tx_data=shift[7:0].
//   After each data handshake, shift>>8; the byte counter runs 0..3.
//  Handshake: a byte transfers only when tx_valid && tx_ready.
//   While tx_valid=1 && tx_ready=0, tx_data must hold stable and tx_valid must stay high.
//   tx_valid never drops without a transfer, except on rst.
//  Back-to-back: with tx_ready held high, one byte per cycle.
//   The exception is a one-cycle bubble for each LOAD.
//  csum ^= every transferred byte except HEADER (index and data bytes only).
//  After byte 3 of LAST_REG, go to CSUM: tx_data=csum.
//   Otherwise reg_idx++, addr_e++, and go to LOAD.
//  DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
//   A start in the DONE cycle is ignored.
//  Frame length: 2 + 5*(LAST_REG-FIRST_REG+1) bytes (157 bytes with defaults).
//  Register 0 reads 0 (regfile rule); it is dumped normally if FIRST_REG=0.
//  Snapshot is per register, not atomic across registers.
//   A register written before its LOAD cycle is dumped with the new value.
//   A register written after its LOAD cycle keeps the captured value.
//  addr_e holds its value between dumps.
// TESTING
//  T1 reset: assert rst 2 cycles mid-dump -> next cycle tx_valid=0, busy=0,
//     done=0, addr_e=0; a new start then restarts with HEADER A5.
//  T2 all regs 0, defaults, tx_ready=1 -> 157 bytes: A5, {01,00,00,00,00}...
//     {1F,00,00,00,00}, checksum 00. done is high one cycle after the last
//     handshake.
//  T3 FIRST_REG=LAST_REG=5, x5=32'hDEADBEEF -> A5 05 EF BE AD DE 27, then done.
//  T4 backpressure: tx_ready=0 for 10 cycles while byte EF is offered.
//     Expect tx_data=EF and tx_valid=1 held stable, no duplicated or lost
//     bytes, and the same frame as T3.
//  T5 start pulses while busy, and in the DONE cycle -> exactly one frame
//     emitted; busy does not re-assert.
//  T6 non-atomic snapshot: x10 starts as 1. Write x10=32'h12345678 during
//     register 3's DATA phase -> register 10 is dumped as 78 56 34 12.
//     Checksum matches the bench model.

Source files
------------

// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: walks FIRST_REG..LAST_REG over the regfile read port and streams
// a HEADER + {index, 4 data bytes}* + XOR checksum byte frame on a valid/ready link.
module regfile_dump_tx #(
    parameter int          FIRST_REG = 1,
    parameter int          LAST_REG  = 31,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  addr_e,
    input  logic [31:0] data_e,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, HDR, LOAD, IDX, DATA, CSUM, DONE} state_t;
    state_t      state, state_n;
    logic [4:0]  reg_idx;
    logic [31:0] shift;
    logic [1:0]  cnt;
    logic [7:0]  csum;
    logic        xfer, last_byte, last_reg;
    always_comb begin
        tx_valid  = state inside {HDR, IDX, DATA, CSUM};
        tx_data   = state == HDR  ? HEADER :
                    state == IDX  ? {3'b000, reg_idx} :
                    state == DATA ? shift[7:0] :
                    state == CSUM ? csum : 8'h00;
        busy      = !(state inside {IDLE, DONE});
        done      = state == DONE;
        xfer      = tx_valid && tx_ready;
        last_byte = cnt == 2'd3;
        last_reg  = reg_idx == 5'(LAST_REG);
        state_n   = state;
        case (state)
            IDLE:    state_n = start ? HDR : IDLE;
            HDR:     state_n = xfer ? LOAD : HDR;
            LOAD:    state_n = IDX;
            IDX:     state_n = xfer ? DATA : IDX;
            DATA:    state_n = !(xfer && last_byte) ? DATA : last_reg ? CSUM : LOAD;
            CSUM:    state_n = xfer ? DONE : CSUM;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    // Checksum covers index and data bytes only; the header is excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_idx <= '0;
            addr_e  <= '0;
            shift   <= '0;
            cnt     <= '0;
            csum    <= '0;
        end else begin
            if (state == IDLE && start) begin
                reg_idx <= 5'(FIRST_REG);
                addr_e  <= 5'(FIRST_REG);
                csum    <= '0;
            end
            if (state == LOAD) begin
                shift <= data_e;
                cnt   <= '0;
            end
            if (xfer && state inside {IDX, DATA})
                csum <= csum ^ tx_data;
            if (xfer && state == DATA) begin
                shift <= shift >> 8;
                cnt   <= cnt + 2'd1;
                if (last_byte && !last_reg) begin
                    reg_idx <= reg_idx + 5'd1;
                    addr_e  <= addr_e + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_dump_tx.sv
// tb_regfile_dump_tx: directed vectors for two instances (full default range, and a
// single-register range at x5) plus frame-level scoreboard sequences.
module tb_regfile_dump_tx;
    logic        clk = 0, rst = 1;
    logic        start_a = 0, start_b = 0, ready_a = 0, ready_b = 0;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [7:0]  txd_a, txd_b;
    logic        v_a, v_b, busy_a, busy_b, done_a, done_b;
    logic [31:0] regs [32];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign data_a = addr_a == 5'd0 ? 32'd0 : regs[addr_a];
    assign data_b = addr_b == 5'd0 ? 32'd0 : regs[addr_b];

    regfile_dump_tx dut_a (
        .clk(clk), .rst(rst), .start(start_a), .addr_e(addr_a), .data_e(data_a),
        .tx_data(txd_a), .tx_valid(v_a), .tx_ready(ready_a), .busy(busy_a), .done(done_a));

    regfile_dump_tx #(.FIRST_REG(5), .LAST_REG(5), .HEADER(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .addr_e(addr_b), .data_e(data_b),
        .tx_data(txd_b), .tx_valid(v_b), .tx_ready(ready_b), .busy(busy_b), .done(done_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       st, rdy, v;
        logic [7:0] d;
        logic       b, dn;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic st, logic rdy, logic v, logic [7:0] d, logic b, logic dn);
        vec_t r;
        r.st = st; r.rdy = rdy; r.v = v; r.d = d; r.b = b; r.dn = dn;
        tbl.push_back(r);
    endfunction

    typedef logic [7:0] bq_t[$];
    logic [7:0] got[$];
    int hs_last, done_at, done_cnt;

    function automatic bq_t build(int f, int l);
        bq_t q;
        logic [7:0] x = 8'h00;
        logic [31:0] v;
        q.push_back(8'hA5);
        for (int r = f; r <= l; r++) begin
            v = (r == 0) ? 32'd0 : regs[r];
            q.push_back(8'(r));
            q.push_back(v[7:0]);
            q.push_back(v[15:8]);
            q.push_back(v[23:16]);
            q.push_back(v[31:24]);
            x = x ^ 8'(r) ^ v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
        end
        q.push_back(x);
        return q;
    endfunction

    // Drives one dump on dut_a; optionally writes x10 once wr_at bytes are committed.
    task automatic run_frame(input bit rnd, input int wr_at);
        got = {};
        hs_last = -1; done_at = -1; done_cnt = 0;
        @(negedge clk); start_a = 1; ready_a = 1;
        @(negedge clk); start_a = 0;
        for (int c = 0; c < 3000; c++) begin
            if (done_a) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && c > done_at + 3) break;
            ready_a = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (v_a && ready_a) begin
                got.push_back(txd_a);
                hs_last = c;
                if (got.size() == wr_at) regs[10] = 32'h12345678;
            end
            @(negedge clk);
        end
        ready_a = 0;
        chk("frame_done_seen", 32'(done_at >= 0), 32'd1);
    endtask

    task automatic cmp_frame(input string name, input bq_t exp);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp[i]));
    endtask

    initial begin
        bq_t exp;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        // Reset state
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_valid", 32'(v_a), 0);
        chk("rst_data", 32'(txd_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_addr", 32'(addr_a), 0);
        // T1: reset mid-dump aborts the frame
        start_a = 1; ready_a = 1;
        @(negedge clk); start_a = 0;
        repeat (20) @(negedge clk);
        chk("t1_busy_mid", 32'(busy_a), 1);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0; ready_a = 0;
        chk("t1_valid", 32'(v_a), 0);
        chk("t1_busy", 32'(busy_a), 0);
        chk("t1_done", 32'(done_a), 0);
        chk("t1_addr", 32'(addr_a), 0);
        // T2: all-zero dump, full default range
        run_frame(0, -1);
        exp = build(1, 31);
        chk("t2_len157", got.size(), 157);
        cmp_frame("t2", exp);
        chk("t2_done_after_last_hs", done_at, hs_last + 1);
        chk("t2_done_one_cycle", done_cnt, 1);
        chk("t2_busy_after", 32'(busy_a), 0);
        // T3/T4/T5 on the single-register instance
        regs[5] = 32'hDEADBEEF;
        add(1, 1, 0, 8'h00, 0, 0);
        add(0, 1, 1, 8'hA5, 1, 0);
        add(0, 1, 0, 8'h00, 1, 0);
        add(0, 1, 1, 8'h05, 1, 0);
        add(0, 1, 1, 8'hEF, 1, 0);
        add(0, 1, 1, 8'hBE, 1, 0);
        add(0, 1, 1, 8'hAD, 1, 0);
        add(0, 1, 1, 8'hDE, 1, 0);
        add(0, 1, 1, 8'h27, 1, 0);
        add(0, 1, 0, 8'h00, 0, 1);
        add(0, 1, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 0, 0);
        add(1, 1, 1, 8'hA5, 1, 0);
        add(0, 1, 0, 8'h00, 1, 0);
        add(1, 1, 1, 8'h05, 1, 0);
        for (int i = 0; i < 10; i++) add(i == 4, 0, 1, 8'hEF, 1, 0);
        add(0, 1, 1, 8'hEF, 1, 0);
        add(0, 1, 1, 8'hBE, 1, 0);
        add(0, 1, 1, 8'hAD, 1, 0);
        add(0, 1, 1, 8'hDE, 1, 0);
        add(0, 1, 1, 8'h27, 1, 0);
        add(1, 1, 0, 8'h00, 0, 1);
        add(0, 1, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(v_b), 32'(tbl[i].v));
            chk($sformatf("vec%0d_busy", i), 32'(busy_b), 32'(tbl[i].b));
            chk($sformatf("vec%0d_done", i), 32'(done_b), 32'(tbl[i].dn));
            if (tbl[i].v) chk($sformatf("vec%0d_data", i), 32'(txd_b), 32'(tbl[i].d));
            start_b = tbl[i].st;
            ready_b = tbl[i].rdy;
        end
        start_b = 0;
        chk("t5_addr_hold", 32'(addr_b), 5);
        // T6: x10 rewritten during register 3 data bytes, random backpressure
        for (int i = 1; i < 32; i++) if (i != 5) regs[i] = 32'h01010101 * i ^ 32'h5A00C300;
        regs[10] = 32'd1;
        run_frame(1, 13);
        chk("t6_x10_written", regs[10], 32'h12345678);
        exp = build(1, 31);
        cmp_frame("t6", exp);
        if (got.size() > 50) begin
            chk("t6_r10_idx", 32'(got[46]), 32'h0A);
            chk("t6_r10_b0", 32'(got[47]), 32'h78);
            chk("t6_r10_b1", 32'(got[48]), 32'h56);
            chk("t6_r10_b2", 32'(got[49]), 32'h34);
            chk("t6_r10_b3", 32'(got[50]), 32'h12);
        end
        chk("t6_done_one_cycle", done_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
